cpu_run_monitor: RTL and testbench

- Synthesizable run controller and checker for the accumulator CPU; replaces fixed-delay reset and `$finish` sequencing with a parametrised FSM.
- Sequences the CPU reset pulse and counts cycles and fetched instructions.
- Detects halt, timeout and PC livelock, and checks the final accumulator and PC against expected values.
- Sits beside the `cpu` instance in a bench top or FPGA self-test wrapper.

---
 rtl/cpu_run_monitor.sv | 144 ++++++++++++++
 tb/tb_cpu_run_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run sequencer and result checker for the accumulator CPU.
// Pulses CPU reset, counts cycles/fetches, flags halt, timeout and livelock.
module cpu_run_monitor #(
  parameter int PC_WIDTH     = 5,
  parameter int AC_WIDTH     = 8,
  parameter int RST_CYCLES   = 2,
  parameter int MAX_CYCLES   = 1000,
  parameter int STALL_CYCLES = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 ld_ir,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [AC_WIDTH-1:0]  acc,
  input  logic [AC_WIDTH-1:0]  exp_acc,
  input  logic [PC_WIDTH-1:0]  exp_pc,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [1:0]           err_code,
  output logic [CNT_WIDTH-1:0] cycles,
  output logic [CNT_WIDTH-1:0] instrs,
  output logic [AC_WIDTH-1:0]  final_acc
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

  localparam logic [RW-1:0] RST_LD = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CYC_LIM = CNT_WIDTH'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RESET,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [RW-1:0]       rcnt;
  logic [SW-1:0]       stall;
  logic [PC_WIDTH-1:0] prev_pc;
  logic [AC_WIDTH-1:0] xacc;
  logic [PC_WIDTH-1:0] xpc;
  logic                hit;
  logic [1:0]          code;

  assign cpu_rst = (state != RUN);
  assign busy    = (state == RESET) || (state == RUN);
  assign done    = (state == DONE);

  // Run-end detection; halt outranks timeout, timeout outranks livelock.
  always_comb begin
    hit  = 1'b0;
    code = 2'd0;
    if (halt) begin
      hit  = 1'b1;
      code = ((acc == xacc) && (pc == xpc)) ? 2'd0 : 2'd1;
    end else if (cycles == CYC_LIM) begin
      hit  = 1'b1;
      code = 2'd2;
    end else if (stall == STALL_LIM) begin
      hit  = 1'b1;
      code = 2'd3;
    end
  end

  // Next-state: start only honoured from IDLE or DONE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RESET;
      RESET:   if (rcnt == '0) state_nx = RUN;
      RUN:     if (hit) state_nx = DONE;
      DONE:    if (start) state_nx = RESET;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Counters, expected values and captured results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt      <= '0;
      stall     <= '0;
      prev_pc   <= '0;
      xacc      <= '0;
      xpc       <= '0;
      cycles    <= '0;
      instrs    <= '0;
      err_code  <= '0;
      pass      <= 1'b0;
      final_acc <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            xacc      <= exp_acc;
            xpc       <= exp_pc;
            cycles    <= '0;
            instrs    <= '0;
            err_code  <= '0;
            pass      <= 1'b0;
            final_acc <= '0;
            stall     <= '0;
            rcnt      <= RST_LD;
          end
        end
        RESET: begin
          if (rcnt != '0) begin
            rcnt <= rcnt - 1'b1;
          end else begin
            prev_pc <= pc;
            stall   <= '0;
          end
        end
        RUN: begin
          if (!(&cycles)) cycles <= cycles + 1'b1;
          if (ld_ir && !(&instrs)) instrs <= instrs + 1'b1;
          prev_pc <= pc;
          stall   <= (pc != prev_pc) ? '0 : stall + 1'b1;
          if (hit) begin
            final_acc <= acc;
            err_code  <= code;
            pass      <= (code == 2'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: randomized CPU stand-in driving cpu_run_monitor.
// Expected run outcome comes from a pc-history model of the checker rules.
module tb_cpu_run_monitor;

  localparam int RST   = 3;
  localparam int MAXC  = 50;
  localparam int STALL = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt;
  logic        ld_ir;
  logic [4:0]  pc;
  logic [7:0]  acc;
  logic [7:0]  exp_acc;
  logic [4:0]  exp_pc;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  err_code;
  logic [15:0] cycles;
  logic [15:0] instrs;
  logic [7:0]  final_acc;

  int nassert = 0;
  int nfail   = 0;

  cpu_run_monitor #(
    .PC_WIDTH(5),
    .AC_WIDTH(8),
    .RST_CYCLES(RST),
    .MAX_CYCLES(MAXC),
    .STALL_CYCLES(STALL),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .halt(halt),
    .ld_ir(ld_ir),
    .pc(pc),
    .acc(acc),
    .exp_acc(exp_acc),
    .exp_pc(exp_pc),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_code(err_code),
    .cycles(cycles),
    .instrs(instrs),
    .final_acc(final_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle();
    chk("idle_cpu_rst", cpu_rst, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_pass", pass, 0);
    chk("idle_err", err_code, 0);
    chk("idle_cycles", cycles, 0);
    chk("idle_instrs", instrs, 0);
    chk("idle_facc", final_acc, 0);
  endtask

  // One run from IDLE or DONE; called and returning at a negedge.
  task automatic do_run(input int halt_at, input int frz_at,
                        input logic [4:0] frz_pc,
                        input logic [7:0] ea, input logic [4:0] ep,
                        input logic [7:0] hacc, input logic [4:0] hpc,
                        input bit poke, input int rst_at);
    logic [4:0] pcs[$];
    logic [4:0] p;
    logic [7:0] a;
    logic       hl;
    logic       li;
    int         k;
    int         st;
    int         nld;
    int         e_err;
    bit         fin;
    exp_acc = ea;
    exp_pc  = ep;
    start   = 1'b1;
    halt    = 1'b0;
    ld_ir   = 1'b0;
    pc      = '0;
    acc     = '0;
    @(negedge clk);
    start   = 1'b0;
    exp_acc = 8'($urandom);
    exp_pc  = 5'($urandom);
    for (int r = 0; r < RST; r++) begin
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_busy", busy, 1);
      chk("rst_done", done, 0);
      chk("rst_cycles", cycles, 0);
      halt  = 1'($urandom);
      ld_ir = 1'($urandom);
      pc    = '0;
      acc   = '0;
      @(negedge clk);
    end
    pcs.push_back(5'd0);
    k   = 0;
    nld = 0;
    fin = 1'b0;
    e_err = 0;
    a   = '0;
    while (!fin && k < MAXC + 10) begin
      k++;
      chk("run_cpu_rst", cpu_rst, 0);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_cycles", cycles, k - 1);
      chk("run_instrs", instrs, nld);
      if (rst_at == k) begin
        start = 1'b0;
        halt  = 1'b0;
        rst   = 1'b0;
        #1;
        chk_idle();
        @(negedge clk);
        chk_idle();
        rst = 1'b1;
        return;
      end
      hl = (k == halt_at);
      if (hl) p = hpc;
      else if (frz_at != 0 && k >= frz_at) p = frz_pc;
      else p = pcs[$] ^ 5'($urandom_range(1, 31));
      a  = hl ? hacc : 8'($urandom);
      li = 1'($urandom);
      pc    = p;
      acc   = a;
      halt  = hl;
      ld_ir = li;
      start = poke && ($urandom_range(0, 3) == 0);
      st = 0;
      for (int j = pcs.size() - 1; j >= 1; j--) begin
        if (pcs[j] != pcs[j-1]) break;
        st++;
      end
      if (li) nld++;
      if (hl) begin
        fin   = 1'b1;
        e_err = (a == ea && p == ep) ? 0 : 1;
      end else if (k - 1 == MAXC - 1) begin
        fin   = 1'b1;
        e_err = 2;
      end else if (st == STALL - 1) begin
        fin   = 1'b1;
        e_err = 3;
      end
      pcs.push_back(p);
      @(negedge clk);
    end
    chk("model_end", fin, 1);
    start = 1'b0;
    halt  = 1'b0;
    for (int h = 0; h < 3; h++) begin
      chk("done_done", done, 1);
      chk("done_busy", busy, 0);
      chk("done_cpu_rst", cpu_rst, 1);
      chk("done_pass", pass, (e_err == 0) ? 1 : 0);
      chk("done_err", err_code, e_err);
      chk("done_cycles", cycles, k);
      chk("done_instrs", instrs, nld);
      chk("done_facc", final_acc, a);
      halt  = 1'($urandom);
      ld_ir = 1'($urandom);
      pc    = 5'($urandom);
      acc   = 8'($urandom);
      @(negedge clk);
    end
    halt = 1'b0;
  endtask

  initial begin
    logic [7:0] ea;
    logic [4:0] ep;
    rst     = 1'b0;
    start   = 1'b0;
    halt    = 1'b0;
    ld_ir   = 1'b0;
    pc      = '0;
    acc     = '0;
    exp_acc = '0;
    exp_pc  = '0;
    @(negedge clk);
    chk_idle();
    rst = 1'b1;
    @(negedge clk);
    chk_idle();

    do_run(20, 0, 5'd0, 8'd42, 5'd7, 8'd42, 5'd7, 1'b0, 0);
    do_run(20, 0, 5'd0, 8'd42, 5'd7, 8'd41, 5'd7, 1'b1, 0);
    do_run(0, 0, 5'd0, 8'd42, 5'd7, 8'd0, 5'd0, 1'b1, 0);
    do_run(0, 10, 5'd3, 8'd42, 5'd7, 8'd0, 5'd0, 1'b0, 0);
    do_run(MAXC, 0, 5'd0, 8'h5a, 5'd9, 8'h5a, 5'd9, 1'b0, 0);
    do_run(MAXC, 0, 5'd0, 8'h5a, 5'd9, 8'h5a, 5'd8, 1'b1, 0);
    do_run(0, 30, 5'd3, 8'd1, 5'd2, 8'd0, 5'd0, 1'b0, 0);
    do_run(30, 0, 5'd0, 8'd42, 5'd7, 8'd42, 5'd7, 1'b1, 15);
    do_run(20, 0, 5'd0, 8'd42, 5'd7, 8'd42, 5'd7, 1'b0, 0);

    for (int t = 0; t < 8; t++) begin
      ea = 8'($urandom);
      ep = 5'($urandom);
      do_run($urandom_range(0, 55), $urandom_range(0, 40),
             5'($urandom), ea, ep,
             ($urandom_range(0, 1) == 1) ? ea : 8'($urandom),
             ($urandom_range(0, 1) == 1) ? ep : 5'($urandom),
             1'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
